// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the
// alignment check used when a request is accepted.
package lsu_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StRmwRd,
        StRmwWr
    } state_e;

    // Misaligned half/word or the reserved size encoding.
    function automatic logic access_err(input size_e sz, input logic [1:0] off);
        logic err;
        case (sz)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = off[0];
            SZ_WORD: err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Big-endian lane logic: extracts and extends the addressed load lane and merges
// the addressed store lane into a read word.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]        offset_i,
    input  size_e             size_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] rword_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] ld_data_o,
    output logic [DATA_W-1:0] merged_o
);

    logic [4:0]        sh;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] mask;
    logic              sign;

    always_comb begin
        sh        = '0;
        lane      = '0;
        mask      = '0;
        sign      = 1'b0;
        ld_data_o = '0;
        merged_o  = rword_i;
        unique case (size_i)
            SZ_BYTE: begin
                // Offset k sits 8*(3-k) bits above bit 0; 3-k == ~k for 2-bit k.
                sh        = {~offset_i, 3'b000};
                lane      = rword_i >> sh;
                mask      = DATA_W'(8'hFF);
                sign      = signed_i & lane[7];
                ld_data_o = (lane & mask) | (sign ? ~mask : '0);
                merged_o  = (rword_i & ~(mask << sh)) | ((wdata_i & mask) << sh);
            end
            SZ_HALF: begin
                sh        = {~offset_i[1], 4'b0000};
                lane      = rword_i >> sh;
                mask      = DATA_W'(16'hFFFF);
                sign      = signed_i & lane[15];
                ld_data_o = (lane & mask) | (sign ? ~mask : '0);
                merged_o  = (rword_i & ~(mask << sh)) | ((wdata_i & mask) << sh);
            end
            SZ_WORD: begin
                ld_data_o = rword_i;
                merged_o  = wdata_i;
            end
            default: begin
                ld_data_o = '0;
                merged_o  = rword_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns byte/half/word loads and stores into word-wide memory
// cycles. Define LSU_COUNTERS_EN to add saturating ld_count/st_count outputs.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wrData,
    input  logic [DATA_W-1:0] mem_rdData
`ifdef LSU_COUNTERS_EN
    ,
    output logic [15:0]       ld_count,
    output logic [15:0]       st_count
`endif
);

    localparam int unsigned OffW = $clog2(BYTES_PER_WORD);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    size_e             size_q, size_d;
    logic              signed_q, signed_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rmw_q, rmw_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] merged;
    logic [ADDR_W-1:0] word_addr;
    size_e             req_size_e;

    assign req_size_e = size_e'(req_size);
    assign word_addr  = {addr_q[ADDR_W-1:OffW], {OffW{1'b0}}};

    lsu_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .offset_i  (addr_q[OffW-1:0]),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .rword_i   (mem_rdData),
        .wdata_i   (wdata_q),
        .ld_data_o (ld_data),
        .merged_o  (merged)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        signed_d     = signed_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        rmw_d        = rmw_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        req_ready    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wrData   = '0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d   = req_addr;
                    size_d   = req_size_e;
                    signed_d = req_signed;
                    write_d  = req_write;
                    wdata_d  = req_wdata;
                    if (access_err(req_size_e, req_addr[OffW-1:0])) begin
                        // Rejected without touching memory; respond next cycle.
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_write) begin
                        state_d = StRd;
                    end else if (req_size_e == SZ_WORD) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StRd: begin
                mem_read     = 1'b1;
                mem_addr     = word_addr;
                resp_rdata_d = ld_data;
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            StWr: begin
                mem_write    = 1'b1;
                mem_addr     = word_addr;
                mem_wrData   = wdata_q;
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            StRmwRd: begin
                mem_read = 1'b1;
                mem_addr = word_addr;
                rmw_d    = merged;
                state_d  = StRmwWr;
            end
            StRmwWr: begin
                mem_write    = 1'b1;
                mem_addr     = word_addr;
                mem_wrData   = rmw_q;
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            rmw_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            rmw_q        <= rmw_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

`ifdef LSU_COUNTERS_EN
    logic        ld_done;
    logic        st_done;
    logic [15:0] ld_count_q;
    logic [15:0] st_count_q;

    // Completing states are only ever reached by error-free requests.
    assign ld_done = (state_q == StRd);
    assign st_done = (state_q == StWr) || (state_q == StRmwWr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_count_q <= '0;
            st_count_q <= '0;
        end else begin
            if (ld_done && (ld_count_q != 16'hFFFF)) begin
                ld_count_q <= ld_count_q + 16'd1;
            end
            if (st_done && (st_count_q != 16'hFFFF)) begin
                st_count_q <= st_count_q + 16'd1;
            end
        end
    end

    assign ld_count = ld_count_q;
    assign st_count = st_count_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small big-endian word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wrData;
    logic [31:0] mem_rdData;
`ifdef LSU_COUNTERS_EN
    logic [15:0] ld_count;
    logic [15:0] st_count;
`endif

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wrData (mem_wrData),
        .mem_rdData (mem_rdData)
`ifdef LSU_COUNTERS_EN
        ,
        .ld_count   (ld_count),
        .st_count   (st_count)
`endif
    );

    // Word memory: index = addr[5:2]; word@0=1, @4=2, @8=3, @12=4, @16=5, @40=0x39.
    logic [31:0] mem [16] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h39, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          misalign = 0;
    logic [31:0] rd_addr = '0;
    logic [31:0] wr_data = '0;

    assign mem_rdData = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_read) begin
            rd_cnt  = rd_cnt + 1;
            rd_addr = mem_addr;
        end
        if (mem_write) begin
            wr_cnt  = wr_cnt + 1;
            wr_data = mem_wrData;
            mem[mem_addr[5:2]] <= mem_wrData;
        end
        if ((mem_read || mem_write) && (mem_addr[1:0] != 2'b00)) begin
            misalign = misalign + 1;
        end
    end

    int          tests = 0;
    int          fails = 0;
    int          lat;
    int          nrd;
    int          nwr;
    int          rd0;
    int          wr0;
    logic [31:0] got_rdata;
    logic        got_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        assert (got === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, wait (bounded) for its response, record latency and memory activity.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        rd0        = rd_cnt;
        wr0        = wr_cnt;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        got_rdata = resp_rdata;
        got_err   = resp_err;
        nrd       = rd_cnt - rd0;
        nwr       = wr_cnt - wr0;
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_en", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wrData", mem_wrData, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Word load
        do_req(1'b0, 2'b10, 1'b0, 32'd40, 32'h0);
        chk("ldw40_lat", 32'(lat), 32'd2);
        chk("ldw40_rdata", got_rdata, 32'h39);
        chk("ldw40_err", 32'(got_err), 32'd0);
        chk("ldw40_nrd", 32'(nrd), 32'd1);
        chk("ldw40_nwr", 32'(nwr), 32'd0);
        chk("ldw40_rdaddr", rd_addr, 32'd40);

        // Byte store through read-modify-write; only the low byte of wdata is used
        do_req(1'b1, 2'b00, 1'b0, 32'd1, 32'hABCDEFFF);
        chk("stb1_lat", 32'(lat), 32'd3);
        chk("stb1_err", 32'(got_err), 32'd0);
        chk("stb1_rdata", got_rdata, 32'h0);
        chk("stb1_nrd", 32'(nrd), 32'd1);
        chk("stb1_nwr", 32'(nwr), 32'd1);
        chk("stb1_wrdata", wr_data, 32'h00FF0001);
        do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'h0);
        chk("ldw0_rdata", got_rdata, 32'h00FF0001);
        do_req(1'b0, 2'b00, 1'b1, 32'd1, 32'h0);
        chk("ldbs1_rdata", got_rdata, 32'hFFFFFFFF);
        chk("ldbs1_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'b00, 1'b0, 32'd1, 32'h0);
        chk("ldbu1_rdata", got_rdata, 32'h000000FF);
        do_req(1'b0, 2'b01, 1'b1, 32'd0, 32'h0);
        chk("ldhs0_rdata", got_rdata, 32'h000000FF);

        // Word store, half store to offset 2, then lane reads of the result
        do_req(1'b1, 2'b10, 1'b0, 32'd16, 32'hCAFEF00D);
        chk("stw16_lat", 32'(lat), 32'd2);
        chk("stw16_nrd", 32'(nrd), 32'd0);
        chk("stw16_wrdata", wr_data, 32'hCAFEF00D);
        do_req(1'b1, 2'b01, 1'b0, 32'd18, 32'h1234BEEF);
        chk("sth18_lat", 32'(lat), 32'd3);
        chk("sth18_wrdata", wr_data, 32'hCAFEBEEF);
        do_req(1'b0, 2'b01, 1'b1, 32'd18, 32'h0);
        chk("ldhs18_rdata", got_rdata, 32'hFFFFBEEF);
        do_req(1'b0, 2'b00, 1'b0, 32'd19, 32'h0);
        chk("ldbu19_rdata", got_rdata, 32'h000000EF);
        do_req(1'b0, 2'b00, 1'b1, 32'd16, 32'h0);
        chk("ldbs16_rdata", got_rdata, 32'hFFFFFFCA);

        // Errors: never touch memory, respond after one cycle
        do_req(1'b0, 2'b10, 1'b0, 32'd2, 32'h0);
        chk("errldw2_lat", 32'(lat), 32'd1);
        chk("errldw2_err", 32'(got_err), 32'd1);
        chk("errldw2_rdata", got_rdata, 32'h0);
        chk("errldw2_mem", 32'(nrd + nwr), 32'd0);
        do_req(1'b1, 2'b01, 1'b0, 32'd3, 32'h5555);
        chk("errsth3_lat", 32'(lat), 32'd1);
        chk("errsth3_err", 32'(got_err), 32'd1);
        chk("errsth3_mem", 32'(nrd + nwr), 32'd0);
        do_req(1'b0, 2'b11, 1'b1, 32'd8, 32'h0);
        chk("errsz11_lat", 32'(lat), 32'd1);
        chk("errsz11_err", 32'(got_err), 32'd1);
        chk("errsz11_rdata", got_rdata, 32'h0);
        chk("errsz11_mem", 32'(nrd + nwr), 32'd0);

`ifdef LSU_COUNTERS_EN
        chk("cnt_ld_pre", 32'(ld_count), 32'd8);
        chk("cnt_st_pre", 32'(st_count), 32'd3);
`endif

        // Reset during RMW_RD of a half store: the write must never happen
        wr0        = wr_cnt;
        req_write  = 1'b1;
        req_size   = 2'b01;
        req_signed = 1'b0;
        req_addr   = 32'd4;
        req_wdata  = 32'h0000ABCD;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rmwrd_mem_read", 32'(mem_read), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp_err", 32'(resp_err), 32'd0);
        chk("abort_resp_rdata", resp_rdata, 32'h0);
        chk("abort_mem_en", {30'd0, mem_read, mem_write}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_mem_wrData", mem_wrData, 32'h0);
`ifdef LSU_COUNTERS_EN
        chk("abort_cnt", {ld_count, st_count}, 32'h0);
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_nwr", 32'(wr_cnt - wr0), 32'd0);
        chk("abort_mem4", mem[1], 32'h00000002);
        do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
        chk("abort_ldw4", got_rdata, 32'h00000002);

        // Back-to-back loads with req_valid held high
        req_write  = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'd8;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_addr = 32'd12;
        @(posedge clk);
        #1;
        chk("b2b_first_valid", 32'(resp_valid), 32'd1);
        chk("b2b_first_rdata", resp_rdata, 32'h3);
        chk("b2b_ready_on_resp", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_second_accepted", 32'(req_ready), 32'd0);
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        chk("b2b_second_lat", 32'(lat), 32'd2);
        chk("b2b_second_rdata", resp_rdata, 32'h4);
        @(posedge clk);
        #1;
        chk("b2b_resp_pulse", 32'(resp_valid), 32'd0);

`ifdef LSU_COUNTERS_EN
        chk("cnt_ld_post", 32'(ld_count), 32'd3);
        chk("cnt_st_post", 32'(st_count), 32'd0);
`endif
        chk("mem_addr_aligned", 32'(misalign), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port; sits between the pipeline MEM stage and the byte-addressed, big-endian, 32-bit data memory.
- The memory reads combinationally and writes only whole 4-byte words on the clock edge.
- This block turns byte, halfword and word loads and stores into legal memory cycles:
  - sub-word stores use read-modify-write;
  - loads get sign or zero extension;
  - misaligned accesses are flagged.

Parameters:
- ADDR_W, 32, address width of request and memory port
- DATA_W, 32, word width; fixed at 4 bytes of 8 bits

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous and active-low: state clears on a posedge clk where rst==0
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend loads (ignored for stores)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; misaligned or illegal size
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable, committed at posedge
- mem_addr  out  ADDR_W  memory address; always word-aligned (low 2 bits 0) when an enable is high
- mem_wrData  out  DATA_W  memory write data
- mem_rdData  in  DATA_W  memory read data, combinational from mem_addr

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_read=0, mem_write=0, mem_addr=0, mem_wrData=0.
- Reset mid-operation aborts. No mem_write is issued after the reset edge, so an RMW aborted in RMW_RD never writes.
- Handshake: a request is accepted on a posedge where req_valid && req_ready. The unit latches addr, size, signed, write flag and wdata.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR.
- Transitions from IDLE on accept:
  - error -> IDLE, with resp_valid=1 and resp_err=1 on the next cycle; no memory enable is ever asserted;
  - load -> RD;
  - word store -> WR;
  - byte or half store -> RMW_RD.
- RD: mem_read=1, mem_addr=addr&~3. At the edge, the selected lane is extended into resp_rdata, the state goes to IDLE, and resp_valid pulses.
  - Load latency: resp_valid exactly 2 cycles after the accept edge.
- WR: mem_write=1, mem_wrData=wdata. Goes to IDLE with resp_valid pulsed. Latency 2.
- RMW_RD: mem_read=1 and the unit captures mem_rdData. RMW_WR: mem_write=1 with the merged word; then IDLE with resp_valid. Latency 3.
- Lanes are big-endian: byte offset k occupies bits [31-8k:24-8k]; a half at offset 0 is [31:16] and at offset 2 is [15:0].
- Merge replaces only the addressed lane, using the low byte or low half of wdata.
- Errors: half with addr[0]=1; word with addr[1:0]!=0; size 11.
- IDLE accepts a new request in the same cycle resp_valid is high (back-to-back allowed).
- resp_valid and resp_err are single-cycle, registered outputs.
- Outputs are registered except mem_read, mem_write, mem_addr and mem_wrData, which decode from state and the latched request.

Optional Feature:
- Macro: LSU_COUNTERS_EN.
- Defined: adds outputs ld_count[15:0] and st_count[15:0].
  - Each increments on the resp_valid of a successful (non-error) load or store.
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: the ports and logic are absent; the behaviour is otherwise identical.

Decomposition:
- lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
  - FSM state enum;
  - BYTES_PER_WORD=4.
- One combinational sub-module, lsu_lane: extracts and extends the load lane, and merges the store lane, given offset and size. The top level keeps the FSM.

Test Plan:
- Memory word@40=0x00000039. Word load addr 40 -> resp_valid 2 cycles after accept, rdata=0x00000039, err=0, one mem_read cycle at addr 40.
- Word@0=0x00000001. Byte store 0xFF at addr 1 -> RMW_RD then RMW_WR with mem_wrData=0x00FF0001, latency 3. Subsequent word load addr 0 -> 0x00FF0001.
- After that store:
  - signed byte load addr 1 -> 0xFFFFFFFF;
  - unsigned -> 0x000000FF;
  - signed half load addr 0 -> 0x000000FF.
- Word load addr 2, half store addr 3, size 11 -> each gives resp_err=1 with rdata=0, 1 cycle after accept; mem_read and mem_write never asserted.
- Drive rst=0 during RMW_RD of a half store to addr 4 -> no mem_write ever; word@4 still 0x00000002; all outputs at reset values; req_ready=1.
- Back-to-back: assert req_valid continuously with load addr 8 then load addr 12 -> rdata 0x3 and then 0x4; the second accept happens on the resp_valid cycle of the first.
- With LSU_COUNTERS_EN: the scenarios above leave ld_count and st_count matching successful ops only; errors are not counted.
